// File: rtl/z80_led_pkg.sv
// Shared constants for the Z80 LED bank controller: register addresses and reset values,
// LED_CTRL field positions, sequencer mode codes and write-FSM state codes.
package z80_led_pkg;

    localparam logic [7:0] LED_DATA_ADDR_DEF = 8'h01;
    localparam logic [7:0] LED_CTRL_ADDR_DEF = 8'h02;

    localparam logic [7:0] LED_DATA_RST = 8'h00;
    localparam logic [7:0] LED_CTRL_RST = 8'h80;

    localparam int CTRL_EN_BIT   = 7;
    localparam int CTRL_RATE_HI  = 4;
    localparam int CTRL_RATE_LO  = 2;
    localparam int CTRL_MODE_HI  = 1;
    localparam int CTRL_MODE_LO  = 0;

    // Bits [6:5] of LED_CTRL read as zero and ignore writes.
    localparam logic [7:0] CTRL_WMASK = 8'h9F;

    typedef enum logic [1:0] {
        MODE_STATIC = 2'b00,
        MODE_BLINK  = 2'b01,
        MODE_ROTL   = 2'b10,
        MODE_ROTR   = 2'b11
    } led_mode_e;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'b00,
        ST_COMMIT   = 2'b01,
        ST_WAIT_REL = 2'b10
    } wr_state_e;

    function automatic logic [7:0] led_view(
        input logic       en,
        input logic [1:0] mode,
        input logic       phase,
        input logic [7:0] pat
    );
        logic [7:0] v;
        if (!en) begin
            v = 8'h00;
        end else if ((mode == MODE_BLINK) && !phase) begin
            v = 8'h00;
        end else begin
            v = pat;
        end
        return v;
    endfunction

endpackage

// File: rtl/led_tick_gen.sv
// Sequencer prescaler: emits a one-cycle step pulse every BASE_DIV<<rate cycles while enabled;
// clear or disable returns the count to zero so the next period starts fresh.
module led_tick_gen #(
    parameter int unsigned BASE_DIV = 1_562_500,
    parameter int          DIV_W    = 32
) (
    input  logic       mclk,
    input  logic       rst_n,
    input  logic       clear,
    input  logic       en,
    input  logic [2:0] rate,
    output logic       step
);

    logic [DIV_W-1:0] count_r;
    logic [DIV_W-1:0] limit_s;
    logic [DIV_W-1:0] last_s;
    logic [DIV_W-1:0] pre_last_s;
    logic             step_r;

    // Period length for the selected rate, and the two terminal count values.
    always_comb begin
        limit_s    = DIV_W'(BASE_DIV) << rate;
        last_s     = limit_s - DIV_W'(1);
        pre_last_s = limit_s - DIV_W'(2);
    end

    // Step is registered one count early so it lines up with the wrap to zero.
    always_ff @(posedge mclk or negedge rst_n) begin
        if (!rst_n) begin
            count_r <= '0;
            step_r  <= 1'b0;
        end else if (clear || !en) begin
            count_r <= '0;
            step_r  <= 1'b0;
        end else begin
            step_r <= (count_r == pre_last_s);
            if (count_r == last_s) begin
                count_r <= '0;
            end else begin
                count_r <= count_r + DIV_W'(1);
            end
        end
    end

    assign step = step_r;

endmodule

// File: rtl/z80_led_ctrl.sv
// Z80 I/O-mapped LED bank controller: LED_DATA/LED_CTRL registers written through a
// registered-strobe FSM, plus a static/blink/rotate sequencer. Optional readback: LED_READBACK_EN.
module z80_led_ctrl
    import z80_led_pkg::*;
#(
    parameter logic [7:0]  DATA_ADDR = LED_DATA_ADDR_DEF,
    parameter logic [7:0]  CTRL_ADDR = LED_CTRL_ADDR_DEF,
    parameter int unsigned BASE_DIV  = 1_562_500,
    parameter int          DIV_W     = 32
) (
    input  logic       mclk,
    input  logic       rst_n,
    input  logic [7:0] io_addr,
    input  logic [7:0] io_wdata,
    input  logic       iorq_n,
    input  logic       wr_n,
    input  logic       rd_n,
    output logic [7:0] io_rdata,
    output logic       io_rd_hit,
    output logic [7:0] Led
);

    logic       strb_r;
    logic [7:0] addr_r;
    logic [7:0] wdata_r;

    wr_state_e  state_r;
    logic       cmd_ctrl_r;
    logic [7:0] cmd_data_r;

    logic [7:0] data_r;
    logic [7:0] ctrl_r;
    logic [7:0] pat_r;
    logic       phase_r;
    logic [7:0] led_r;

    logic       data_hit_s;
    logic       ctrl_hit_s;
    logic       commit_s;
    logic       step_s;

    logic [7:0] data_n;
    logic [7:0] ctrl_n;
    logic [7:0] pat_n;
    logic       phase_n;
    logic [7:0] led_n;

    logic [7:0] rdata_r;
    logic       rd_hit_r;

    // Sample the bus once so the FSM works from a single registered view of the strobe.
    always_ff @(posedge mclk or negedge rst_n) begin
        if (!rst_n) begin
            strb_r  <= 1'b1;
            addr_r  <= 8'h00;
            wdata_r <= 8'h00;
        end else begin
            strb_r  <= iorq_n | wr_n;
            addr_r  <= io_addr;
            wdata_r <= io_wdata;
        end
    end

    // Address decode of the registered bus and commit strobe.
    always_comb begin
        data_hit_s = (addr_r == DATA_ADDR);
        ctrl_hit_s = (addr_r == CTRL_ADDR);
        commit_s   = (state_r == ST_COMMIT);
    end

    // Write FSM: one commit per low strobe, then wait for the strobe to rise.
    always_ff @(posedge mclk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_IDLE;
            cmd_ctrl_r <= 1'b0;
            cmd_data_r <= 8'h00;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (!strb_r && (data_hit_s || ctrl_hit_s)) begin
                        state_r    <= ST_COMMIT;
                        cmd_ctrl_r <= !data_hit_s;
                        cmd_data_r <= wdata_r;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_COMMIT: begin
                    state_r <= ST_WAIT_REL;
                end
                ST_WAIT_REL: begin
                    if (strb_r) begin
                        state_r <= ST_IDLE;
                    end else begin
                        state_r <= ST_WAIT_REL;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    led_tick_gen #(
        .BASE_DIV (BASE_DIV),
        .DIV_W    (DIV_W)
    ) u_tick (
        .mclk  (mclk),
        .rst_n (rst_n),
        .clear (commit_s),
        .en    (ctrl_r[CTRL_EN_BIT]),
        .rate  (ctrl_r[CTRL_RATE_HI:CTRL_RATE_LO]),
        .step  (step_s)
    );

    // Next register/pattern state; a CPU commit takes priority over a coincident step.
    always_comb begin
        data_n  = data_r;
        ctrl_n  = ctrl_r;
        pat_n   = pat_r;
        phase_n = phase_r;
        if (commit_s) begin
            if (cmd_ctrl_r) begin
                ctrl_n = cmd_data_r & CTRL_WMASK;
                pat_n  = data_r;
            end else begin
                data_n = cmd_data_r;
                pat_n  = cmd_data_r;
            end
            phase_n = 1'b1;
        end else if (step_s && ctrl_r[CTRL_EN_BIT]) begin
            case (ctrl_r[CTRL_MODE_HI:CTRL_MODE_LO])
                MODE_STATIC: pat_n   = pat_r;
                MODE_BLINK:  phase_n = !phase_r;
                MODE_ROTL:   pat_n   = {pat_r[6:0], pat_r[7]};
                MODE_ROTR:   pat_n   = {pat_r[0], pat_r[7:1]};
                default:     pat_n   = pat_r;
            endcase
        end else begin
            pat_n = pat_r;
        end
        led_n = led_view(ctrl_n[CTRL_EN_BIT], ctrl_n[CTRL_MODE_HI:CTRL_MODE_LO], phase_n, pat_n);
    end

    // Register file, sequencer pattern and LED drive.
    always_ff @(posedge mclk or negedge rst_n) begin
        if (!rst_n) begin
            data_r  <= LED_DATA_RST;
            ctrl_r  <= LED_CTRL_RST;
            pat_r   <= LED_DATA_RST;
            phase_r <= 1'b1;
            led_r   <= 8'h00;
        end else begin
            data_r  <= data_n;
            ctrl_r  <= ctrl_n;
            pat_r   <= pat_n;
            phase_r <= phase_n;
            led_r   <= led_n;
        end
    end

`ifdef LED_READBACK_EN
    // Readback: registered data and hit flag follow the raw read strobe by one edge.
    always_ff @(posedge mclk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_r  <= 8'h00;
            rd_hit_r <= 1'b0;
        end else if (!iorq_n && !rd_n && (io_addr == DATA_ADDR)) begin
            rdata_r  <= data_r;
            rd_hit_r <= 1'b1;
        end else if (!iorq_n && !rd_n && (io_addr == CTRL_ADDR)) begin
            rdata_r  <= ctrl_r;
            rd_hit_r <= 1'b1;
        end else begin
            rdata_r  <= 8'h00;
            rd_hit_r <= 1'b0;
        end
    end
`else
    logic unused_rd_s;
    assign unused_rd_s = rd_n;

    // Without readback the read port is parked at an idle bus value.
    always_ff @(posedge mclk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_r  <= 8'hFF;
            rd_hit_r <= 1'b0;
        end else begin
            rdata_r  <= 8'hFF;
            rd_hit_r <= 1'b0;
        end
    end
`endif

    assign io_rdata  = rdata_r;
    assign io_rd_hit = rd_hit_r;
    assign Led       = led_r;

endmodule
